// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and small decode helpers for access size and legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Right-aligned byte-lane mask for the access size encoded in funct3.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            F3_W:        size_mask = 4'b1111;
            default:     size_mask = 4'b0000;
        endcase
    endfunction

    // Number of bytes touched by the access (1, 2 or 4).
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd1:    size_bytes = 3'd2;
            2'd2:    size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

    // Stores only have signless B/H/W; loads add the unsigned B/H forms.
    function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
        if (store)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and extraction/extension for
// loads. hi_phase selects the upper-word half of a split access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        hi_phase,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_data,
    input  logic [31:0] hi_data,
    output logic [3:0]  strb,
    output logic [31:0] sdata,
    output logic [31:0] rdata
);

    logic [7:0]  mask_shl;
    logic [3:0]  mask;
    logic [63:0] window;

    // Store path: low word shifts lanes up by off, upper word takes the spill-over.
    always_comb begin
        mask     = size_mask(funct3);
        mask_shl = {4'b0000, mask} << off;
        if (!hi_phase) begin
            strb  = mask_shl[3:0];
            sdata = wdata << {off, 3'b000};
        end else begin
            strb  = mask >> (3'd4 - {1'b0, off});
            sdata = wdata >> (6'd32 - {1'b0, off, 3'b000});
        end
    end

    // Load path: shift the two-word window down by off, then size/extend.
    always_comb begin
        window = {hi_data, lo_data} >> {off, 3'b000};
        case (funct3)
            F3_B:    rdata = {{24{window[7]}}, window[7:0]};
            F3_H:    rdata = {{16{window[15]}}, window[15:0]};
            F3_W:    rdata = window[31:0];
            F3_BU:   rdata = {24'h000000, window[7:0]};
            F3_HU:   rdata = {16'h0000, window[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the pipeline and a byte-strobed data memory.
// One request in flight; IDLE -> ACC0 [-> ACC1] -> RESP.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses
// are split into two memory cycles; otherwise they fault without touching
// memory. Faulted responses always carry zero read data.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_store_i,
    input  logic [2:0]          req_funct3_i,
    input  logic [AWIDTH-1:0]   req_addr_i,
    input  logic [DWIDTH-1:0]   req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DWIDTH-1:0]   resp_rdata_o,
    output logic                resp_fault_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_data_o,
    output logic [DWIDTH/8-1:0] mem_write_strb_o,
    output logic                mem_read_en_o,
    output logic                mem_write_en_o,
    input  logic [DWIDTH-1:0]   mem_data_i,
    input  logic                mem_data_vld_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e        state_reg, state_next;
    logic              store_reg;
    logic [2:0]        funct3_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [DWIDTH-1:0] wdata_reg;
    logic [DWIDTH-1:0] lo_reg;
    logic              fault_reg;
    logic [DWIDTH-1:0] hi_data;
    logic              req_legal;
    logic              req_cross;
    logic              align_hi;
    logic [3:0]        align_strb;
    logic [31:0]       align_sdata;
    logic [31:0]       align_rdata;

    assign req_legal = f3_legal(req_store_i, req_funct3_i);
    assign req_cross = ({1'b0, req_addr_i[1:0]} + size_bytes(req_funct3_i)) > 3'd4;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [DWIDTH-1:0] hi_reg;
    logic              cross_reg;
    logic [AWIDTH-3:0] word_next;

    assign hi_data   = hi_reg;
    assign cross_reg = ({1'b0, addr_reg[1:0]} + size_bytes(funct3_reg)) > 3'd4;
    // Upper word of a split access; wraps at the top of the address space.
    assign word_next = addr_reg[AWIDTH-1:2] + {{(AWIDTH-3){1'b0}}, 1'b1};
`else
    assign hi_data = '0;
`endif

    // State register plus request capture and load-data/fault accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            store_reg  <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            lo_reg     <= '0;
            fault_reg  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_reg     <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        store_reg  <= req_store_i;
                        funct3_reg <= req_funct3_i;
                        addr_reg   <= req_addr_i;
                        wdata_reg  <= req_wdata_i;
                        fault_reg  <= !req_legal || (req_cross && !SPLIT_EN);
                    end
                end
                ACC0: begin
                    if (!store_reg) begin
                        lo_reg <= mem_data_i;
                        if (!mem_data_vld_i)
                            fault_reg <= 1'b1;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1: begin
                    if (!store_reg) begin
                        hi_reg <= mem_data_i;
                        if (!mem_data_vld_i)
                            fault_reg <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Next-state decode and per-state drive of handshake and memory outputs.
    always_comb begin
        state_next       = state_reg;
        req_ready_o      = 1'b0;
        resp_valid_o     = 1'b0;
        mem_read_en_o    = 1'b0;
        mem_write_en_o   = 1'b0;
        mem_addr_o       = '0;
        mem_data_o       = '0;
        mem_write_strb_o = '0;
        align_hi         = 1'b0;
        case (state_reg)
            IDLE: begin
                // Ready is masked while reset is held so every output reads 0.
                req_ready_o = rst;
                if (req_valid_i && rst) begin
                    if (!req_legal || (req_cross && !SPLIT_EN))
                        state_next = RESP;
                    else
                        state_next = ACC0;
                end
            end
            ACC0: begin
                mem_addr_o       = {addr_reg[AWIDTH-1:2], 2'b00};
                mem_data_o       = align_sdata;
                mem_write_strb_o = align_strb;
                mem_read_en_o    = !store_reg;
                mem_write_en_o   = store_reg;
`ifdef LSU_MISALIGN_SPLIT_EN
                state_next = cross_reg ? ACC1 : RESP;
`else
                state_next = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                align_hi         = 1'b1;
                mem_addr_o       = {word_next, 2'b00};
                mem_data_o       = align_sdata;
                mem_write_strb_o = align_strb;
                mem_read_en_o    = !store_reg;
                mem_write_en_o   = store_reg;
                state_next       = RESP;
            end
`endif
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    lsu_align u_align (
        .funct3   (funct3_reg),
        .off      (addr_reg[1:0]),
        .hi_phase (align_hi),
        .wdata    (wdata_reg),
        .lo_data  (lo_reg),
        .hi_data  (hi_data),
        .strb     (align_strb),
        .sdata    (align_sdata),
        .rdata    (align_rdata)
    );

    // Response fields are only non-zero while presenting a response.
    assign resp_fault_o = (state_reg == RESP) && fault_reg;
    assign resp_rdata_o = ((state_reg == RESP) && !store_reg && !fault_reg) ? align_rdata : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a byte-strobed memory model.
// Honours LSU_MISALIGN_SPLIT_EN the same way as the design.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_fault_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_write_strb_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;
    logic        mem_data_vld_i;

    logic        mem_vld_tb = 1'b1;
    logic        mem_clear = 1'b1;
    logic [7:0]  mem [0:255];

    int pass_cnt = 0;
    int tot_cnt = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int resp_cyc = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        we;
    } acc_t;
    acc_t acc_q[$];

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [31:0] WORD8_FINAL = 32'hCAFE1122;
`else
    localparam logic [31:0] WORD8_FINAL = 32'hCAFEBABE;
`endif

    lsu_mem_ctrl #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_store_i      (req_store_i),
        .req_funct3_i     (req_funct3_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_rdata_o     (resp_rdata_o),
        .resp_fault_o     (resp_fault_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_write_strb_o (mem_write_strb_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_write_en_o   (mem_write_en_o),
        .mem_data_i       (mem_data_i),
        .mem_data_vld_i   (mem_data_vld_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 256-byte window aliased on addr[7:0], combinational read.
    always_comb begin
        mem_data_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] lane;
            lane = i[1:0];
            mem_data_i[8*i +: 8] = mem[{mem_addr_o[7:2], lane}];
        end
    end
    assign mem_data_vld_i = mem_vld_tb;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_write_en_o) begin
            for (int i = 0; i < 4; i++) begin
                logic [1:0] lane;
                lane = i[1:0];
                if (mem_write_strb_o[i]) mem[{mem_addr_o[7:2], lane}] <= mem_data_o[8*i +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Access logger: records every memory cycle, checks enable exclusivity.
    always @(negedge clk) begin
        if (rst && (mem_read_en_o || mem_write_en_o)) begin
            acc_t a;
            chk("enables_exclusive", {31'b0, mem_read_en_o & mem_write_en_o}, 32'h0);
            a.addr = mem_addr_o;
            a.data = mem_data_o;
            a.strb = mem_write_strb_o;
            a.we   = mem_write_en_o;
            acc_q.push_back(a);
        end
    end

    // Response monitor: pops the scoreboard on each accepted response.
    always @(negedge clk) begin
        if (rst && resp_valid_o && !prev_valid) resp_cyc = cyc;
        if (rst && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_resp: got rdata 0x%08h, expected no response", resp_rdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("resp %s: rdata=0x%08h fault=%0d lat=%0d", e.name, resp_rdata_o,
                         resp_fault_o, resp_cyc - accept_cyc + 1);
                chk({e.name, "_rdata"}, resp_rdata_o, e.rdata);
                chk({e.name, "_fault"}, {31'b0, resp_fault_o}, {31'b0, e.fault});
                chk({e.name, "_lat"}, resp_cyc - accept_cyc + 1, e.lat);
            end
        end
        prev_valid = rst && resp_valid_o;
    end

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready_o}, 32'h1);
        req_valid_i  = 1'b1;
        req_store_i  = st;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
        @(posedge clk);
        #1;
        accept_cyc  = cyc;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tot_cnt++;
            $display("FAIL timeout_%s: got no response in 20 cycles, expected one", nm);
            exp_q.delete();
        end
    endtask

    task automatic issue(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef, input int el);
        exp_t e;
        e.rdata = er; e.fault = ef; e.lat = el; e.name = nm;
        exp_q.push_back(e);
        acc_q.delete();
        send(st, f3, a, wd);
        wait_resp(nm);
    endtask

    task automatic chk_acc(input string nm, input int idx, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic we);
        if (idx >= acc_q.size()) begin
            tot_cnt++;
            $display("FAIL %s_missing: got %0d accesses, expected index %0d", nm, acc_q.size(), idx);
        end else begin
            chk({nm, "_addr"}, acc_q[idx].addr, a);
            chk({nm, "_strb"}, {28'b0, acc_q[idx].strb}, {28'b0, s});
            if (we) chk({nm, "_data"}, acc_q[idx].data, d);
            chk({nm, "_we"}, {31'b0, acc_q[idx].we}, {31'b0, we});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready_o}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        rst = 1'b1;
        mem_clear = 1'b0;
        #1 chk("rst_release_ready", {31'b0, req_ready_o}, 32'h1);

        // Aligned word store then load
        issue("sw_aligned", 1'b1, 3'd2, 32'h0100_0008, 32'hCAFEBABE, 32'h0, 1'b0, 2);
        chk("sw_aligned_naccess", acc_q.size(), 1);
        chk_acc("sw_aligned_acc0", 0, 32'h0100_0008, 4'b1111, 32'hCAFEBABE, 1'b1);
        issue("lw_aligned", 1'b0, 3'd2, 32'h0100_0008, 32'h0, 32'hCAFEBABE, 1'b0, 2);
        chk_acc("lw_aligned_acc0", 0, 32'h0100_0008, 4'b1111, 32'h0, 1'b0);

        // Byte store at offset 1, then signed/unsigned byte and half loads
        issue("sb_off1", 1'b1, 3'd0, 32'h0100_0011, 32'h0000_00F0, 32'h0, 1'b0, 2);
        chk_acc("sb_off1_acc0", 0, 32'h0100_0010, 4'b0010, 32'h0000_F000, 1'b1);
        issue("lb_off1", 1'b0, 3'd0, 32'h0100_0011, 32'h0, 32'hFFFF_FFF0, 1'b0, 2);
        issue("lbu_off1", 1'b0, 3'd4, 32'h0100_0011, 32'h0, 32'h0000_00F0, 1'b0, 2);
        issue("lh_off0", 1'b0, 3'd1, 32'h0100_0010, 32'h0, 32'hFFFF_F000, 1'b0, 2);
        issue("lhu_off0", 1'b0, 3'd5, 32'h0100_0010, 32'h0, 32'h0000_F000, 1'b0, 2);

        // Word-crossing accesses
`ifdef LSU_MISALIGN_SPLIT_EN
        issue("sw_split", 1'b1, 3'd2, 32'h0100_0006, 32'h1122_3344, 32'h0, 1'b0, 3);
        chk("sw_split_naccess", acc_q.size(), 2);
        chk_acc("sw_split_acc0", 0, 32'h0100_0004, 4'b1100, 32'h3344_0000, 1'b1);
        chk_acc("sw_split_acc1", 1, 32'h0100_0008, 4'b0011, 32'h0000_1122, 1'b1);
        issue("lw_split", 1'b0, 3'd2, 32'h0100_0006, 32'h0, 32'h1122_3344, 1'b0, 3);
        chk("lw_split_naccess", acc_q.size(), 2);
        issue("lh_split", 1'b0, 3'd1, 32'h0100_0007, 32'h0, 32'h0000_2233, 1'b0, 3);
        issue("lhu_wrap", 1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 3);
        chk_acc("lhu_wrap_acc0", 0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 1'b0);
        chk_acc("lhu_wrap_acc1", 1, 32'h0000_0000, 4'b0001, 32'h0, 1'b0);
`else
        issue("sw_cross", 1'b1, 3'd2, 32'h0100_0006, 32'h1122_3344, 32'h0, 1'b1, 1);
        chk("sw_cross_naccess", acc_q.size(), 0);
        issue("lw_cross", 1'b0, 3'd2, 32'h0100_0006, 32'h0, 32'h0, 1'b1, 1);
        chk("lw_cross_naccess", acc_q.size(), 0);
        issue("lh_cross", 1'b0, 3'd1, 32'h0100_0007, 32'h0, 32'h0, 1'b1, 1);
        chk("lh_cross_naccess", acc_q.size(), 0);
`endif

        // Illegal funct3
        issue("ld_f3_3", 1'b0, 3'd3, 32'h0100_0008, 32'h0, 32'h0, 1'b1, 1);
        chk("ld_f3_3_naccess", acc_q.size(), 0);
        issue("st_f3_4", 1'b1, 3'd4, 32'h0100_0008, 32'h1234_5678, 32'h0, 1'b1, 1);
        chk("st_f3_4_naccess", acc_q.size(), 0);

        // Memory read not valid
        mem_vld_tb = 1'b0;
        issue("lw_invalid", 1'b0, 3'd2, 32'h0100_0008, 32'h0, 32'h0, 1'b1, 2);
        mem_vld_tb = 1'b1;

        // Response back-pressure
        begin
            exp_t e;
            int n;
            e.rdata = 32'h0000_F000; e.fault = 1'b0; e.lat = 2; e.name = "lw_hold";
            exp_q.push_back(e);
            resp_ready_i = 1'b0;
            send(1'b0, 3'd2, 32'h0100_0010, 32'h0);
            n = 0;
            while (!resp_valid_o && n < 10) begin @(negedge clk); n++; end
            held = resp_rdata_o;
            chk("hold_first_rdata", held, 32'h0000_F000);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'b0, resp_valid_o}, 32'h1);
                chk("hold_rdata", resp_rdata_o, held);
                chk("hold_req_ready", {31'b0, req_ready_o}, 32'h0);
            end
            @(posedge clk);
            #1 resp_ready_i = 1'b1;
            @(posedge clk);
            #1;
            chk("release_req_ready", {31'b0, req_ready_o}, 32'h1);
            chk("release_resp_valid", {31'b0, resp_valid_o}, 32'h0);
            wait_resp("lw_hold");
        end

        // Asynchronous reset in the middle of ACC0
        send(1'b0, 3'd2, 32'h0100_0008, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("arst_read_en", {31'b0, mem_read_en_o}, 32'h0);
        chk("arst_mem_addr", mem_addr_o, 32'h0);
        chk("arst_req_ready", {31'b0, req_ready_o}, 32'h0);
        chk("arst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("arst_release_ready", {31'b0, req_ready_o}, 32'h1);
        issue("lw_after_rst", 1'b0, 3'd2, 32'h0100_0008, 32'h0, WORD8_FINAL, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
